// File: rtl/frame_tx_11011.sv
// Serial frame transmitter: sync word, then an MSB-first payload byte with
// zero-stuffing so the sync pattern never reappears inside the payload.
module frame_tx_11011 #(
  parameter logic [4:0] SYNC = 5'b11011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       signal,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cntNext;
  logic [7:0] r_data;
  logic [3:0] r_hist;
  logic       w_stuff;
  logic       w_bitNext;
  logic       w_accept;

  // r_hist holds the last four emitted bits including the one now on the line,
  // so its LSB is the serial output and the stuff decision needs no lookahead.
  assign w_stuff  = (r_hist == 4'b1101);
  assign w_accept = (r_state == S_IDLE) && start;
  assign signal   = valid & r_hist[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cntNext = r_cnt;
    valid     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next    = S_SYNC;
          w_cntNext = 3'd4;
        end
      end
      S_SYNC: begin
        valid = 1'b1;
        if (r_cnt == 3'd0) begin
          w_cntNext = 3'd7;
          w_next    = w_stuff ? S_STUFF : S_DATA;
        end else begin
          w_cntNext = r_cnt - 3'd1;
        end
      end
      S_DATA: begin
        valid = 1'b1;
        // The final payload bit is never followed by a stuff slot.
        if (r_cnt == 3'd0) begin
          w_next = S_DONE;
        end else begin
          w_cntNext = r_cnt - 3'd1;
          w_next    = w_stuff ? S_STUFF : S_DATA;
        end
      end
      S_STUFF: begin
        valid  = 1'b1;
        w_next = S_DATA;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_bitNext = 1'b0;
    case (w_next)
      S_SYNC:  w_bitNext = SYNC[w_cntNext];
      S_DATA:  w_bitNext = r_data[w_cntNext];
      default: w_bitNext = 1'b0;
    endcase
  end

  // Payload is captured only on acceptance; history restarts empty each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 3'd0;
      r_data <= 8'd0;
      r_hist <= 4'd0;
    end else begin
      r_cnt <= w_cntNext;
      if (w_accept) begin
        r_data <= din;
        r_hist <= {3'b000, w_bitNext};
      end else if ((w_next == S_SYNC) || (w_next == S_DATA) || (w_next == S_STUFF)) begin
        r_hist <= {r_hist[2:0], w_bitNext};
      end
    end
  end

endmodule
